// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and a configurable frame format.
// The frame is start bit, DATA_WIDTH data bits (LSB first), an optional
// parity bit, then STOP_BITS stop bits. tx is registered, so the line follows
// the FSM state one cycle later and never glitches.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle high, waiting for the FIFO to hold a byte
// S_START  | start bit (low) for one bit time
// S_DATA   | data bits, shift-register LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | stop bit(s) high; pops the next byte with no idle gap
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 1000,
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  empty,
   output logic                  busy,
   output logic                  overflow,
   output logic                  tx
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CLK_W = $clog2(CLKS_PER_BIT * 2);

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [CLK_W-1:0] STOP_LAST = CLK_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  overflow_q, overflow_d;

   state_t                state_q, state_d;
   logic [CLK_W-1:0]      clk_cnt_q, clk_cnt_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head;

   // Full is judged on the registered count, so a same-cycle pop never admits a write.
   assign push = we && !full_q;
   assign head = mem_q[rd_ptr_q];

   // FIFO storage; no reset needed because reset clears the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // FIFO pointer, count and flag next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = we && full_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   // FIFO pointer, count and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Frame FSM: next state, bit timing, FIFO pop and line level.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = 1'b1;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty_q) begin
               pop       = 1'b1;
               shift_d   = head;
               par_d     = (PARITY == 2) ? ~(^head) : ^head;
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = shift_q >> 1;
               if (bit_idx_q == DATA_LAST) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            tx_d = par_q;
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (clk_cnt_q == STOP_LAST) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               if (!empty_q) begin
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = (PARITY == 2) ? ~(^head) : ^head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            tx_d      = 1'b1;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // Frame FSM registers; tx resets high so an aborted frame releases the line at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = overflow_q;
   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE) || !empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E1, 8O1 and
// 7N2 at 4 clocks per bit. A line monitor decodes frames from the selected
// instance; the main sequence compares them to hand-computed bit patterns.
module tb_uart_tx_fifo;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n;
   logic       we0, we1, we2, we3;
   logic [7:0] din0, din1, din2;
   logic [6:0] din3;
   logic       tx_v [4];
   logic       full_v [4];
   logic       empty_v [4];
   logic       busy_v [4];
   logic       ovf_v [4];

   int         sel;
   logic       tx_sel, full_sel, empty_sel, busy_sel, ovf_sel;
   int         cyc;
   int         mon_nbits;
   int         checks;
   int         failures;

   logic [15:0] mq_bits [$];
   bit          mq_ok [$];
   int          mq_start [$];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .we(we0), .din(din0), .full(full_v[0]), .empty(empty_v[0]),
      .busy(busy_v[0]), .overflow(ovf_v[0]), .tx(tx_v[0]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .we(we1), .din(din1), .full(full_v[1]), .empty(empty_v[1]),
      .busy(busy_v[1]), .overflow(ovf_v[1]), .tx(tx_v[1]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .we(we2), .din(din2), .full(full_v[2]), .empty(empty_v[2]),
      .busy(busy_v[2]), .overflow(ovf_v[2]), .tx(tx_v[2]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
      .clk(clk), .rst_n(rst_n), .we(we3), .din(din3), .full(full_v[3]), .empty(empty_v[3]),
      .busy(busy_v[3]), .overflow(ovf_v[3]), .tx(tx_v[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      tx_sel    = 1'b1;
      full_sel  = 1'b0;
      empty_sel = 1'b1;
      busy_sel  = 1'b0;
      ovf_sel   = 1'b0;
      if (sel >= 0 && sel < 4) begin
         tx_sel    = tx_v[sel];
         full_sel  = full_v[sel];
         empty_sel = empty_v[sel];
         busy_sel  = busy_v[sel];
         ovf_sel   = ovf_v[sel];
      end
   end

   // Line monitor: on a low level, sample every cycle of mon_nbits bit times,
   // require each bit to be steady, and queue the frame with its start cycle.
   initial begin
      logic        b;
      logic [15:0] bits;
      bit          ok;
      bit          abort;
      int          st;
      forever begin
         @(posedge clk); #1;
         if (rst_n && tx_sel === 1'b0) begin
            st    = cyc;
            bits  = '0;
            ok    = 1'b1;
            abort = 1'b0;
            for (int i = 0; i < mon_nbits; i++) begin
               b = tx_sel;
               for (int c = 0; c < CPB; c++) begin
                  if (c > 0) begin
                     @(posedge clk); #1;
                  end
                  if (!rst_n) abort = 1'b1;
                  if (tx_sel !== b) ok = 1'b0;
               end
               bits[i] = b;
               if (i < mon_nbits - 1) begin
                  @(posedge clk); #1;
               end
            end
            if (!abort) begin
               mq_bits.push_back(bits);
               mq_ok.push_back(ok);
               mq_start.push_back(st);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] d);
      we0 = 1'b0; we1 = 1'b0; we2 = 1'b0; we3 = 1'b0;
      case (sel)
         0: begin we0 = w; din0 = d; end
         1: begin we1 = w; din1 = d; end
         2: begin we2 = w; din2 = d; end
         default: begin we3 = w; din3 = d[6:0]; end
      endcase
   endtask

   // One write strobe; returns at #1 after the edge that captured it.
   task automatic write_byte(input logic [7:0] d);
      drive(1'b1, d);
      step(1);
      drive(1'b0, 8'h00);
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp_bits, input int exp_start);
      int n;
      n = 0;
      while (mq_bits.size() == 0 && n < 3000) begin
         step(1);
         n++;
      end
      chk({tag, "_seen"}, 32'(mq_bits.size() != 0), 32'd1);
      if (mq_bits.size() != 0) begin
         chk({tag, "_bits"}, 32'(mq_bits.pop_front()), 32'(exp_bits));
         chk({tag, "_steady"}, 32'(mq_ok.pop_front()), 32'd1);
         chk({tag, "_start"}, 32'(mq_start.pop_front()), 32'(exp_start));
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy_sel !== 1'b0 && n < 2000) begin
         step(1);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy_sel), 32'd0);
   endtask

   initial begin
      int          w;
      logic [7:0]  pa [5];
      logic [7:0]  pb [5];
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      sel       = 0;
      mon_nbits = 10;
      rst_n     = 1'b0;
      we0 = 1'b0; we1 = 1'b0; we2 = 1'b0; we3 = 1'b0;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
      pa = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      pb = '{8'h81, 8'h12, 8'h34, 8'h56, 8'h78};

      step(3);
      chk("rst_tx", 32'(tx_sel), 32'd1);
      chk("rst_full", 32'(full_sel), 32'd0);
      chk("rst_empty", 32'(empty_sel), 32'd1);
      chk("rst_busy", 32'(busy_sel), 32'd0);
      chk("rst_ovf", 32'(ovf_sel), 32'd0);
      rst_n = 1'b1;
      step(2);

      // 8N1 0xA5: tx low two edges after the write, 40-cycle frame.
      write_byte(8'hA5);
      w = cyc;
      chk("a5_busy_start", 32'(busy_sel), 32'd1);
      chk("a5_empty_after_push", 32'(empty_sel), 32'd0);
      step(1);
      chk("a5_tx_e1", 32'(tx_sel), 32'd1);
      step(39);
      chk("a5_busy_last_stop", 32'(busy_sel), 32'd1);
      step(1);
      chk("a5_busy_fall", 32'(busy_sel), 32'd0);
      check_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, w + 2);
      step(5);
      chk("a5_no_extra", 32'(mq_bits.size()), 32'd0);

      // Five consecutive writes while idle: the first pop makes room for the fifth.
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, pa[k]);
         step(1);
         if (k == 0) w = cyc;
         if (k == 3) chk("pa_full_before_5th", 32'(full_sel), 32'd0);
         if (k == 4) chk("pa_full_after_5th", 32'(full_sel), 32'd1);
      end
      drive(1'b0, 8'h00);
      step(1);
      chk("pa_no_ovf", 32'(ovf_sel), 32'd0);
      for (int k = 0; k < 5; k++) begin
         check_frame("pa", {6'b0, 1'b1, pa[k], 1'b0}, w + 2 + 40 * k);
      end
      wait_idle("pa");

      // Writes mid-frame: four accepted, fifth overflows; then a write on the
      // edge that pops a full FIFO is still rejected.
      write_byte(pb[0]);
      w = cyc;
      step(9);
      for (int k = 1; k < 6; k++) begin
         drive(1'b1, (k < 5) ? pb[k] : 8'h9A);
         step(1);
         if (k == 4) begin
            chk("pb_full4", 32'(full_sel), 32'd1);
            chk("pb_ovf_before", 32'(ovf_sel), 32'd0);
         end
         if (k == 5) chk("pb_ovf_pulse", 32'(ovf_sel), 32'd1);
      end
      drive(1'b0, 8'h00);
      step(1);
      chk("pb_ovf_one_cycle", 32'(ovf_sel), 32'd0);
      chk("pb_still_full", 32'(full_sel), 32'd1);
      step(25);
      chk("pb_full_before_pop", 32'(full_sel), 32'd1);
      write_byte(8'hEE);
      chk("pop_ovf_pulse", 32'(ovf_sel), 32'd1);
      chk("pop_full_clear", 32'(full_sel), 32'd0);
      chk("pop_not_empty", 32'(empty_sel), 32'd0);
      step(1);
      chk("pop_ovf_end", 32'(ovf_sel), 32'd0);
      for (int k = 0; k < 5; k++) begin
         check_frame("pb", {6'b0, 1'b1, pb[k], 1'b0}, w + 2 + 40 * k);
      end
      wait_idle("pb");
      step(2);
      chk("pb_dropped_not_sent", 32'(mq_bits.size()), 32'd0);

      // Reset in the middle of the data bits of 0x00.
      write_byte(8'h00);
      step(9);
      chk("mid_tx_low", 32'(tx_sel), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx_sel), 32'd1);
      chk("mid_rst_empty", 32'(empty_sel), 32'd1);
      chk("mid_rst_busy", 32'(busy_sel), 32'd0);
      step(3);
      rst_n = 1'b1;
      step(50);
      chk("mid_no_frame", 32'(mq_bits.size()), 32'd0);
      write_byte(8'h3C);
      w = cyc;
      check_frame("post_rst", {6'b0, 1'b1, 8'h3C, 1'b0}, w + 2);
      wait_idle("post_rst");

      // Even parity: 0x07 has three ones, parity bit 1; 44-cycle frame.
      sel       = 1;
      mon_nbits = 11;
      step(1);
      write_byte(8'h07);
      w = cyc;
      check_frame("even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, w + 2);
      wait_idle("even");

      // Odd parity with the same byte: parity bit 0.
      sel = 2;
      step(1);
      write_byte(8'h07);
      w = cyc;
      check_frame("odd", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, w + 2);
      wait_idle("odd");

      // 7 data bits, 2 stop bits: 0x55 gives 1010101 then 8 cycles high.
      sel       = 3;
      mon_nbits = 10;
      step(1);
      write_byte(8'h55);
      w = cyc;
      check_frame("s2", {6'b0, 2'b11, 7'h55, 1'b0}, w + 2);
      wait_idle("s2");
      step(2);
      chk("s2_no_extra", 32'(mq_bits.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
